// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcodes, ALU operation classes, the packed
// micro-op layout and the decode-stage occupancy states.
package decode_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    ALU_MEM     = 3'b000,
    ALU_R       = 3'b001,
    ALU_IMM     = 3'b010,
    ALU_BR      = 3'b011,
    ALU_UPPER   = 3'b100,
    ALU_JUMP    = 3'b101,
    ALU_ILLEGAL = 3'b111
  } alu_op_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        alu_src;
    alu_op_e     alu_op;
    logic        branch;
    logic [2:0]  br_type;
    logic        jump;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_f3;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic        uses_pc;
    logic        pad;
  } uop_t;

  // Width is derived from the struct so port widths can never drift from it.
  localparam int UOP_W = $bits(uop_t);

  // Occupancy encoded as {skid valid, output register valid}.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b01,
    ST_FULL2 = 2'b11
  } stage_state_e;

  // ORI, XORI and ANDI are the logic immediates that may be zero-extended.
  function automatic logic is_logic_f3(input logic [2:0] f3);
    return (f3 == 3'b100) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational RV32I decoder for one lane: instruction plus PC to micro-op.
// Absent lanes decode to an all-zero uop carrying the illegal/NOP ALU class.
module decode_lane
  import decode_pkg::*;
#(
  parameter bit ZEXT_LOGIC_IMM = 1'b1
) (
  input  logic        lane_valid,
  input  logic [31:0] inst,
  input  logic [31:0] pc,
  output uop_t        uop
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign f3     = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = inst[11:7];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_s = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    // NOTE: every field gets a default before any branch so no path leaves
    // a bit unassigned, which would otherwise infer a latch.
    uop        = '0;
    uop.alu_op = ALU_ILLEGAL;
    if (lane_valid) begin
      uop.pc = pc;
      case (opcode)
        OP_R: begin
          uop.rs1       = rs1;
          uop.rs2       = rs2;
          uop.rd        = rd;
          uop.alu_op    = ALU_R;
          uop.reg_write = 1'b1;
        end
        OP_IMM: begin
          uop.rs1       = rs1;
          uop.rd        = rd;
          uop.imm       = (ZEXT_LOGIC_IMM && is_logic_f3(f3)) ? {20'b0, inst[31:20]} : imm_i;
          uop.alu_src   = 1'b1;
          uop.alu_op    = ALU_IMM;
          uop.reg_write = 1'b1;
        end
        OP_LOAD: begin
          uop.rs1        = rs1;
          uop.rd         = rd;
          uop.imm        = imm_i;
          uop.alu_src    = 1'b1;
          uop.alu_op     = ALU_MEM;
          uop.mem_read   = 1'b1;
          uop.mem_to_reg = 1'b1;
          uop.mem_f3     = f3;
          uop.reg_write  = 1'b1;
        end
        OP_STORE: begin
          uop.rs1       = rs1;
          uop.rs2       = rs2;
          uop.imm       = imm_s;
          uop.alu_src   = 1'b1;
          uop.alu_op    = ALU_MEM;
          uop.mem_write = 1'b1;
          uop.mem_f3    = f3;
        end
        OP_BRANCH: begin
          // funct3 010/011 are unassigned branch encodings.
          if (f3 == 3'b010 || f3 == 3'b011) begin
            uop.illegal = 1'b1;
          end else begin
            uop.rs1     = rs1;
            uop.rs2     = rs2;
            uop.imm     = imm_b;
            uop.alu_op  = ALU_BR;
            uop.branch  = 1'b1;
            uop.br_type = f3;
          end
        end
        OP_LUI: begin
          uop.rd        = rd;
          uop.imm       = imm_u;
          uop.alu_op    = ALU_UPPER;
          uop.reg_write = 1'b1;
        end
        OP_AUIPC: begin
          uop.rd        = rd;
          uop.imm       = imm_u;
          uop.alu_src   = 1'b1;
          uop.alu_op    = ALU_UPPER;
          uop.uses_pc   = 1'b1;
          uop.reg_write = 1'b1;
        end
        OP_JAL: begin
          uop.rd        = rd;
          uop.imm       = imm_j;
          uop.alu_op    = ALU_JUMP;
          uop.jump      = 1'b1;
          uop.uses_pc   = 1'b1;
          uop.reg_write = 1'b1;
        end
        OP_JALR: begin
          uop.rs1       = rs1;
          uop.rd        = rd;
          uop.imm       = imm_i;
          uop.alu_src   = 1'b1;
          uop.alu_op    = ALU_JUMP;
          uop.jump      = 1'b1;
          uop.reg_write = 1'b1;
        end
        default: uop.illegal = 1'b1;
      endcase
      // NOTE: blocking assignments in combinational logic, so this override
      // sees the rd value written above.
      if (uop.rd == 5'd0) uop.reg_write = 1'b0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Registered multi-lane decode stage: output register plus one skid entry of
// decoded uops, valid/ready on both sides, flush drops everything held.
module decode_stage
  import decode_pkg::*;
#(
  parameter int WIDTH          = 2,
  parameter bit ZEXT_LOGIC_IMM = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*32-1:0]    in_inst,
  input  logic [WIDTH-1:0]       in_lane_mask,
  input  logic [31:0]            in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_lane_mask,
  output logic [WIDTH*UOP_W-1:0] out_uop
);

  stage_state_e           state_q, state_d;
  uop_t [WIDTH-1:0]       dec_uop;
  uop_t [WIDTH-1:0]       or_uop_q, or_uop_d;
  uop_t [WIDTH-1:0]       sk_uop_q, sk_uop_d;
  logic [WIDTH-1:0]       or_mask_q, or_mask_d;
  logic [WIDTH-1:0]       sk_mask_q, sk_mask_d;
  logic                   accept;
  logic                   drain;

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    decode_lane #(
      .ZEXT_LOGIC_IMM(ZEXT_LOGIC_IMM)
    ) u_lane (
      .lane_valid(in_lane_mask[i]),
      .inst      (in_inst[32*i +: 32]),
      .pc        (in_pc + (32'(i) << 2)),
      .uop       (dec_uop[i])
    );
  end

  // in_ready is a decode of the state flop only; it never sees out_ready.
  assign in_ready      = (state_q != ST_FULL2);
  assign out_valid     = (state_q != ST_EMPTY);
  assign out_lane_mask = or_mask_q;
  assign out_uop       = or_uop_q;
  assign accept        = in_valid & in_ready;
  assign drain         = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    or_uop_d  = or_uop_q;
    or_mask_d = or_mask_q;
    sk_uop_d  = sk_uop_q;
    sk_mask_d = sk_mask_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            or_uop_d  = dec_uop;
            or_mask_d = in_lane_mask;
            state_d   = ST_FULL1;
          end
        end
        ST_FULL1: begin
          if (accept && drain) begin
            or_uop_d  = dec_uop;
            or_mask_d = in_lane_mask;
          end else if (accept) begin
            sk_uop_d  = dec_uop;
            sk_mask_d = in_lane_mask;
            state_d   = ST_FULL2;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL2: begin
          if (drain) begin
            or_uop_d  = sk_uop_q;
            or_mask_d = sk_mask_q;
            state_d   = ST_FULL1;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the data registers are reset too, because out_uop and
    // out_lane_mask must read zero straight out of reset.
    if (rst) begin
      state_q   <= ST_EMPTY;
      or_uop_q  <= '0;
      or_mask_q <= '0;
      sk_uop_q  <= '0;
      sk_mask_q <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values.
      state_q   <= state_d;
      or_uop_q  <= or_uop_d;
      or_mask_q <= or_mask_d;
      sk_uop_q  <= sk_uop_d;
      sk_mask_q <= sk_mask_d;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (WIDTH=2): handshake, skid, flush, reset and
// per-lane decode corners against hand-computed uops.
module tb_decode_stage;
  import decode_pkg::*;

  localparam int W = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [W*32-1:0]      in_inst;
  logic [W-1:0]         in_lane_mask;
  logic [31:0]          in_pc;
  logic                 out_valid;
  logic                 out_ready;
  logic [W-1:0]         out_lane_mask;
  logic [W*UOP_W-1:0]   out_uop;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] I_ADDI_X5  = 32'h09A00293;
  localparam logic [31:0] I_BEQ      = 32'hFE008CE3;
  localparam logic [31:0] I_ORI      = 32'hBAD06193;
  localparam logic [31:0] I_ADDI_X0  = 32'h00100013;
  localparam logic [31:0] I_JAL      = 32'h010000EF;
  localparam logic [31:0] I_LW       = 32'h00812303; // lw x6, 8(x2)
  localparam logic [31:0] I_SW       = 32'h00712623; // sw x7, 12(x2)
  localparam logic [31:0] I_BR_BAD   = 32'h00002063; // branch funct3=010
  localparam logic [31:0] I_AUIPC    = 32'h12345517; // auipc x10, 0x12345

  decode_stage #(
    .WIDTH         (W),
    .ZEXT_LOGIC_IMM(1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_inst      (in_inst),
    .in_lane_mask (in_lane_mask),
    .in_pc        (in_pc),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_lane_mask(out_lane_mask),
    .out_uop      (out_uop)
  );

  always #5 clk = ~clk;

  function automatic uop_t lane_uop(input int i);
    return uop_t'(out_uop[UOP_W*i +: UOP_W]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i0, input logic [31:0] i1,
                       input logic [1:0] m, input logic [31:0] pc);
    in_valid     = 1'b1;
    in_inst      = {i1, i0};
    in_lane_mask = m;
    in_pc        = pc;
  endtask

  // ADDI xk, x0, k in lane 0 tags bundle k; lane 0 PC is 0x1000*k.
  function automatic logic [31:0] tag_inst(input int k);
    return {12'(k), 5'd0, 3'b000, 5'(k), 7'b0010011};
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_lane_mask = '0; in_pc = '0;
    repeat (2) tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (out_lane_mask !== 2'b00) begin n_fail++; $display("FAIL reset_lane_mask: got %b want 00", out_lane_mask); end
    n_checks++; if (out_uop !== '0) begin n_fail++; $display("FAIL reset_out_uop: got %h want 0", out_uop); end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    uop_t e0, e1;
    e0 = '0; e0.pc = 32'h100; e0.rd = 5'd5; e0.imm = 32'd154; e0.alu_src = 1'b1;
    e0.alu_op = ALU_IMM; e0.reg_write = 1'b1;
    e1 = '0; e1.pc = 32'h104; e1.rs1 = 5'd1; e1.imm = 32'hFFFFFFF8;
    e1.alu_op = ALU_BR; e1.branch = 1'b1; e1.br_type = 3'b000;
    out_ready = 1'b1;
    drive(I_ADDI_X5, I_BEQ, 2'b11, 32'h100);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b want 1", out_valid); end
    n_checks++; if (out_lane_mask !== 2'b11) begin n_fail++; $display("FAIL single_lane_mask: got %b want 11", out_lane_mask); end
    n_checks++; if (lane_uop(0).alu_op !== ALU_IMM) begin n_fail++; $display("FAIL single_l0_aluop: got %b want 010", lane_uop(0).alu_op); end
    n_checks++; if (lane_uop(0) !== e0) begin n_fail++; $display("FAIL single_l0_uop: got %h want %h", lane_uop(0), e0); end
    n_checks++; if (lane_uop(1) !== e1) begin n_fail++; $display("FAIL single_l1_uop: got %h want %h", lane_uop(1), e1); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive(tag_inst(1), I_ADDI_X0, 2'b11, 32'h1000);
    tick();
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after1: got %b want 1", in_ready); end
    drive(tag_inst(2), I_ADDI_X0, 2'b11, 32'h2000);
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_after2: got %b want 0", in_ready); end
    drive(tag_inst(3), I_ADDI_X0, 2'b11, 32'h3000);
    tick();
    n_checks++; if (lane_uop(0).pc !== 32'h1000) begin n_fail++; $display("FAIL b2b_hold_first: got %h want 00001000", lane_uop(0).pc); end
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_stall_ready: got %b want 0", in_ready); end
    out_ready = 1'b1;
    tick();
    n_checks++; if (lane_uop(0).pc !== 32'h2000 || lane_uop(0).rd !== 5'd2) begin n_fail++; $display("FAIL b2b_second: got pc %h rd %0d want 00002000 rd 2", lane_uop(0).pc, lane_uop(0).rd); end
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || lane_uop(0).pc !== 32'h3000 || lane_uop(0).rd !== 5'd3) begin n_fail++; $display("FAIL b2b_third: got v %b pc %h rd %0d want v 1 pc 00003000 rd 3", out_valid, lane_uop(0).pc, lane_uop(0).rd); end
    tick();
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_no_dup: got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(tag_inst(5), I_ADDI_X0, 2'b11, 32'h5000);
    tick();
    drive(tag_inst(6), I_ADDI_X0, 2'b11, 32'h6000);
    tick();
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_full2: got %b want 0", in_ready); end
    drive(tag_inst(7), I_ADDI_X0, 2'b11, 32'h7000);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_stale: cycle %0d got %b want 0", c, out_valid); end
    end
    drive(tag_inst(10), I_ADDI_X0, 2'b11, 32'hA000);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || lane_uop(0).pc !== 32'hA000) begin n_fail++; $display("FAIL flush_recover: got v %b pc %h want v 1 pc 0000a000", out_valid, lane_uop(0).pc); end
    tick();
  endtask

  task automatic test_decode_corners();
    uop_t e0, e1;
    out_ready = 1'b1;
    drive(I_ORI, I_ADDI_X0, 2'b11, 32'h200);
    tick();
    e0 = '0; e0.pc = 32'h200; e0.rd = 5'd3; e0.imm = 32'h00000BAD; e0.alu_src = 1'b1;
    e0.alu_op = ALU_IMM; e0.reg_write = 1'b1;
    e1 = '0; e1.pc = 32'h204; e1.imm = 32'd1; e1.alu_src = 1'b1; e1.alu_op = ALU_IMM;
    n_checks++; if (lane_uop(0).imm !== 32'h00000BAD) begin n_fail++; $display("FAIL ori_zext_imm: got %h want 00000bad", lane_uop(0).imm); end
    n_checks++; if (lane_uop(0) !== e0) begin n_fail++; $display("FAIL ori_uop: got %h want %h", lane_uop(0), e0); end
    n_checks++; if (lane_uop(1).reg_write !== 1'b0) begin n_fail++; $display("FAIL addi_x0_regwrite: got %b want 0", lane_uop(1).reg_write); end
    n_checks++; if (lane_uop(1) !== e1) begin n_fail++; $display("FAIL addi_x0_uop: got %h want %h", lane_uop(1), e1); end

    drive(32'h0, I_JAL, 2'b11, 32'h300);
    tick();
    e0 = '0; e0.pc = 32'h300; e0.illegal = 1'b1; e0.alu_op = ALU_ILLEGAL;
    e1 = '0; e1.pc = 32'h304; e1.rd = 5'd1; e1.imm = 32'd16; e1.alu_op = ALU_JUMP;
    e1.jump = 1'b1; e1.uses_pc = 1'b1; e1.reg_write = 1'b1;
    n_checks++; if (lane_uop(0) !== e0) begin n_fail++; $display("FAIL zero_inst_illegal: got %h want %h", lane_uop(0), e0); end
    n_checks++; if (lane_uop(1) !== e1) begin n_fail++; $display("FAIL jal_uop: got %h want %h", lane_uop(1), e1); end

    drive(I_LW, I_SW, 2'b11, 32'h400);
    tick();
    e0 = '0; e0.pc = 32'h400; e0.rs1 = 5'd2; e0.rd = 5'd6; e0.imm = 32'd8; e0.alu_src = 1'b1;
    e0.alu_op = ALU_MEM; e0.mem_read = 1'b1; e0.mem_to_reg = 1'b1; e0.mem_f3 = 3'b010;
    e0.reg_write = 1'b1;
    e1 = '0; e1.pc = 32'h404; e1.rs1 = 5'd2; e1.rs2 = 5'd7; e1.imm = 32'd12; e1.alu_src = 1'b1;
    e1.alu_op = ALU_MEM; e1.mem_write = 1'b1; e1.mem_f3 = 3'b010;
    n_checks++; if (lane_uop(0) !== e0) begin n_fail++; $display("FAIL lw_uop: got %h want %h", lane_uop(0), e0); end
    n_checks++; if (lane_uop(1) !== e1) begin n_fail++; $display("FAIL sw_uop: got %h want %h", lane_uop(1), e1); end

    drive(I_BR_BAD, I_AUIPC, 2'b11, 32'h500);
    tick();
    in_valid = 1'b0;
    e0 = '0; e0.pc = 32'h500; e0.illegal = 1'b1; e0.alu_op = ALU_ILLEGAL;
    e1 = '0; e1.pc = 32'h504; e1.rd = 5'd10; e1.imm = 32'h12345000; e1.alu_src = 1'b1;
    e1.alu_op = ALU_UPPER; e1.uses_pc = 1'b1; e1.reg_write = 1'b1;
    n_checks++; if (lane_uop(0) !== e0) begin n_fail++; $display("FAIL bad_branch_uop: got %h want %h", lane_uop(0), e0); end
    n_checks++; if (lane_uop(1) !== e1) begin n_fail++; $display("FAIL auipc_uop: got %h want %h", lane_uop(1), e1); end
    tick();
  endtask

  task automatic test_lane_mask();
    uop_t e1;
    out_ready = 1'b1;
    drive(I_ADDI_X5, I_JAL, 2'b01, 32'hFFFFFFFC);
    tick();
    e1 = '0; e1.alu_op = ALU_ILLEGAL;
    n_checks++; if (out_lane_mask !== 2'b01) begin n_fail++; $display("FAIL mask_out: got %b want 01", out_lane_mask); end
    n_checks++; if (lane_uop(1) !== e1) begin n_fail++; $display("FAIL mask_lane1_nop: got %h want %h", lane_uop(1), e1); end
    n_checks++; if (lane_uop(0).pc !== 32'hFFFFFFFC) begin n_fail++; $display("FAIL mask_lane0_pc: got %h want fffffffc", lane_uop(0).pc); end
    drive(I_ADDI_X5, I_JAL, 2'b11, 32'hFFFFFFFC);
    tick();
    in_valid = 1'b0;
    n_checks++; if (lane_uop(1).pc !== 32'h00000000 || lane_uop(1).jump !== 1'b1) begin n_fail++; $display("FAIL pc_wrap_lane1: got pc %h jump %b want 00000000 jump 1", lane_uop(1).pc, lane_uop(1).jump); end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive(tag_inst(8), I_ADDI_X0, 2'b11, 32'h8000);
    tick();
    drive(tag_inst(9), I_ADDI_X0, 2'b11, 32'h9000);
    tick();
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL rstmid_full2: got v %b r %b want v 1 r 0", out_valid, in_ready); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_async_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_async_ready: got %b want 1", in_ready); end
    n_checks++; if (out_uop !== '0) begin n_fail++; $display("FAIL rstmid_uop_cleared: got %h want 0", out_uop); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_no_stale: cycle %0d got v %b r %b want v 0 r 1", c, out_valid, in_ready); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_flush();
    test_decode_corners();
    test_lane_mask();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
